trigger_ctrl: RTL and testbench
===============================

# trigger_ctrl

Parametrised start-trigger controller for the F1-program testbench. It holds the CPU under test in reset via `triggerRst` until a masked, debounced trigger is accepted. After an optional start delay it releases the CPU. It then runs forever (one-shot mode) or for a programmed number of cycles before re-arming (auto-rearm mode). It also reports which trigger inputs caused the start and how long the current run has lasted.

## Interface
- `N_TRIG`, default 1: number of trigger inputs; must be ≥1.
- `DEBOUNCE`, default 1: consecutive sampling edges the qualified trigger must be high before acceptance; must be ≥1.
- `START_DELAY`, default 0: cycles spent in DELAY between acceptance and RUN; must be ≥0.
- `RUN_W`, default 16: width of `run_len` and `run_count`.
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `trigger`, in, N_TRIG: raw trigger levels.
- `trig_mask`, in, N_TRIG: per-input enable. Qualified trigger is `q = |(trigger & trig_mask)`.
- `mode`, in, 1: 0 = one-shot (RUN until `rst`/`rearm`); 1 = auto-rearm after `run_len` cycles.
- `run_len`, in, RUN_W: run length for mode 1; 0 means unlimited.
- `rearm`, in, 1: synchronous request to return to IDLE.
- `triggerRst`, out, 1: high whenever state ≠ RUN.
- `running`, out, 1: high when state = RUN.
- `trig_src`, out, N_TRIG: `trigger & trig_mask` captured at the acceptance edge.
- `run_count`, out, RUN_W: cycles elapsed in the current RUN.

## Operation
- States: IDLE, QUAL, DELAY, RUN.
- Outputs are Moore: `triggerRst = (state != RUN)`, `running = (state == RUN)`.
- Internal `armed` flag: 1 after reset. Cleared on leaving RUN (expiry or `rearm`) and on `rearm` in any state. Set at any edge where `q=0`. IDLE ignores `q` while `armed=0`, which prevents immediate re-trigger from a held level.
- IDLE: at an edge with `armed=1` and `q=1`:
  - DEBOUNCE=1: accept.
  - DEBOUNCE>1: go to QUAL with debounce count = 1.
- QUAL:
  - `q=0`: return to IDLE; count is discarded.
  - `q=1`: increment count; accept when the count reaches DEBOUNCE.
- Acceptance edge:
  - latch `trig_src`, `mode` and `run_len` into internal copies;
  - next state is DELAY if START_DELAY>0, else RUN.
- DELAY: exactly START_DELAY cycles, then RUN. `q` is ignored.
- RUN:
  - `run_count` is 0 in the first RUN cycle, increments every edge and saturates at all-ones.
  - Latched mode 0, or latched `run_len`=0: stay in RUN.
  - Latched mode 1 with `run_len`=L>0: at the edge where `run_count == L-1`, go to IDLE. RUN therefore lasts exactly L cycles.
- `rearm`: next state IDLE from any state; debounce and delay counts are cleared.
- `run_count` and `trig_src` hold their last values in IDLE, QUAL and DELAY. `run_count` is cleared on entry to RUN.
- Priority per edge: `rst` > `rearm` > expiry/acceptance > count/hold.
- `mode` and `run_len` changes after acceptance have no effect until the next acceptance.

## Timing
- Reset values: state IDLE, `triggerRst`=1, `running`=0, `trig_src`=0, `run_count`=0, `armed`=1, internal counts 0.
- `q` high at sampling edges k … k+DEBOUNCE-1 → acceptance at edge k+DEBOUNCE-1.
- RUN is entered after edge k+DEBOUNCE-1+START_DELAY; `triggerRst` is low in the following cycle.
  - Default parameters: `q` sampled high at edge k → `triggerRst` low immediately after edge k.
- Mode 1 expiry: `triggerRst` is high one cycle after the last RUN cycle. Re-acceptance needs `q` low for ≥1 edge, then a fresh debounce.
- `rst` asserted mid-DELAY or mid-RUN: IDLE and reset values after that edge. If `q` is still high at the first edge after `rst` drops, acceptance proceeds because `armed`=1.
- `rearm` and `q=1` on the same edge: `rearm` wins. `armed`=0, so the held trigger does not restart.

## Test plan
- Defaults (N_TRIG=1, DEBOUNCE=1, START_DELAY=0), `trig_mask`=1, `trigger` rises before edge 5 → `triggerRst` low after edge 5, stays low 100 cycles with `trigger` removed. `run_count` reads 0,1,2,…
- N_TRIG=4, DEBOUNCE=3, `trig_mask`=4'b0101:
  - pulse `trigger`=4'b0010 → no start;
  - `trigger`=4'b0100 for 2 edges then low → no start;
  - held 3 edges → acceptance, `trig_src`=4'b0100.
- START_DELAY=4, DEBOUNCE=1, trigger sampled at edge 10 → `triggerRst` stays 1 through edge 14, 0 after edge 14.
- Mode 1, `run_len`=5, `trigger` held high → exactly 5 cycles `running`=1, then IDLE with no restart. Drop `trigger` 1 cycle and re-raise → new run, `run_count` restarts at 0.
- `rst` at RUN cycle 3 → all outputs at reset values next cycle. `trigger` high at `rst` release → RUN after first edge.
- `rearm` asserted coincident with held trigger in RUN → IDLE, `triggerRst`=1, no restart until `trigger` toggles low/high.

Source files
------------

// File: rtl/trigger_ctrl.sv
// Start-trigger controller: holds the CPU under test in reset until a masked,
// debounced trigger is accepted, then releases it for a one-shot or bounded run.

module trig_lane (
  input  logic trigger,
  input  logic mask,
  output logic hit
);
  assign hit = trigger & mask;
endmodule

module trigger_ctrl #(
  parameter int N_TRIG      = 1,
  parameter int DEBOUNCE    = 1,
  parameter int START_DELAY = 0,
  parameter int RUN_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_TRIG-1:0] trigger,
  input  logic [N_TRIG-1:0] trig_mask,
  input  logic              mode,
  input  logic [RUN_W-1:0]  run_len,
  input  logic              rearm,
  output logic              triggerRst,
  output logic              running,
  output logic [N_TRIG-1:0] trig_src,
  output logic [RUN_W-1:0]  run_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_QUAL  = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int DLW = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [DLW-1:0] DLY_LAST = DLW'((START_DELAY > 0) ? START_DELAY - 1 : 0);

  typedef struct packed {
    logic             mode;
    logic [RUN_W-1:0] len;
  } run_cfg_t;

  logic [1:0]        state, state_n;
  logic [DBW-1:0]    deb_cnt, deb_n;
  logic [DLW-1:0]    dly_cnt, dly_n;
  logic              armed, armed_n;
  run_cfg_t          cfg;
  logic [N_TRIG-1:0] hit;
  logic              q, accept, take, expire;

  for (genvar g = 0; g < N_TRIG; g++) begin : g_lane
    trig_lane u_lane (
      .trigger (trigger[g]),
      .mask    (trig_mask[g]),
      .hit     (hit[g])
    );
  end

  assign q = |hit;

  always_comb begin
    expire = (state == S_RUN) && cfg.mode && (cfg.len != '0) &&
             (run_count == cfg.len - RUN_W'(1));
    accept = ((state == S_IDLE) && armed && q && (DEBOUNCE == 1)) ||
             ((state == S_QUAL) && q && (deb_cnt == DEB_LAST));
    take   = accept && !rearm;

    state_n = state;
    deb_n   = deb_cnt;
    dly_n   = dly_cnt;
    if (rearm) begin
      state_n = S_IDLE;
      deb_n   = '0;
      dly_n   = '0;
    end else if (expire) begin
      state_n = S_IDLE;
    end else if (accept) begin
      state_n = (START_DELAY > 0) ? S_DELAY : S_RUN;
      deb_n   = '0;
      dly_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          // an unarmed IDLE ignores a trigger level still held from the last run
          if (armed && q) begin
            state_n = S_QUAL;
            deb_n   = DBW'(1);
          end
        end
        S_QUAL: begin
          if (!q) begin
            state_n = S_IDLE;
            deb_n   = '0;
          end else begin
            deb_n = deb_cnt + DBW'(1);
          end
        end
        S_DELAY: begin
          if (dly_cnt == DLY_LAST) begin
            state_n = S_RUN;
            dly_n   = '0;
          end else begin
            dly_n = dly_cnt + DLW'(1);
          end
        end
        default: ;
      endcase
    end

    if (rearm || expire) armed_n = 1'b0;
    else if (!q)         armed_n = 1'b1;
    else                 armed_n = armed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      deb_cnt   <= '0;
      dly_cnt   <= '0;
      armed     <= 1'b1;
      cfg       <= '0;
      trig_src  <= '0;
      run_count <= '0;
    end else begin
      state   <= state_n;
      deb_cnt <= deb_n;
      dly_cnt <= dly_n;
      armed   <= armed_n;
      if (take) begin
        trig_src <= hit;
        cfg.mode <= mode;
        cfg.len  <= run_len;
      end
      // count restarts on RUN entry; the expiry edge holds the final value
      if (state_n == S_RUN && state != S_RUN)
        run_count <= '0;
      else if (state == S_RUN && state_n == S_RUN && run_count != '1)
        run_count <= run_count + RUN_W'(1);
    end
  end

  assign triggerRst = (state != S_RUN);
  assign running    = (state == S_RUN);

endmodule

// File: tb/tb_trigger_ctrl.sv
// Bench for trigger_ctrl: three parameterisations on shared stimulus, checked
// every cycle against a timestamp-based model plus directed literal checks.

module tb_trigger_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode, rearm;
  logic [3:0]  trig, mask;
  logic [15:0] run_len;

  logic        tr0, run0, tr1, run1, tr2, run2;
  logic [0:0]  src0;
  logic [3:0]  src1;
  logic [1:0]  src2;
  logic [15:0] rc0, rc2;
  logic [3:0]  rc1;

  trigger_ctrl #(.N_TRIG(1), .DEBOUNCE(1), .START_DELAY(0), .RUN_W(16)) u0 (
    .clk(clk), .rst(rst), .trigger(trig[0:0]), .trig_mask(mask[0:0]), .mode(mode),
    .run_len(run_len), .rearm(rearm), .triggerRst(tr0), .running(run0),
    .trig_src(src0), .run_count(rc0));

  trigger_ctrl #(.N_TRIG(4), .DEBOUNCE(3), .START_DELAY(0), .RUN_W(4)) u1 (
    .clk(clk), .rst(rst), .trigger(trig), .trig_mask(mask), .mode(mode),
    .run_len(run_len[3:0]), .rearm(rearm), .triggerRst(tr1), .running(run1),
    .trig_src(src1), .run_count(rc1));

  trigger_ctrl #(.N_TRIG(2), .DEBOUNCE(1), .START_DELAY(4), .RUN_W(16)) u2 (
    .clk(clk), .rst(rst), .trigger(trig[1:0]), .trig_mask(mask[1:0]), .mode(mode),
    .run_len(run_len), .rearm(rearm), .triggerRst(tr2), .running(run2),
    .trig_src(src2), .run_count(rc2));

  int         P_D    [3] = '{1, 3, 1};
  int         P_SD   [3] = '{0, 0, 4};
  int         P_MAX  [3] = '{65535, 15, 65535};
  logic [3:0] P_WM   [3] = '{4'b0001, 4'b1111, 4'b0011};

  // model: a run is described by the edge index at which RUN begins
  bit         m_act   [3];
  bit         m_armed [3];
  bit         m_mode  [3];
  int         m_streak[3];
  int         m_run_at[3];
  int         m_rc    [3];
  int         m_len   [3];
  logic [3:0] m_src   [3];
  int         ecnt;

  int nvec = 0;
  int nerr = 0;

  function automatic int sat(int v, int i);
    return (v > P_MAX[i]) ? P_MAX[i] : v;
  endfunction

  function automatic bit exp_run(int i);
    return m_act[i] && (ecnt >= m_run_at[i]);
  endfunction

  function automatic int exp_rc(int i);
    return exp_run(i) ? sat(ecnt - m_run_at[i], i) : m_rc[i];
  endfunction

  function automatic int dut_out(int i, int which);
    case (i)
      0: case (which) 0: return int'(tr0); 1: return int'(run0); 2: return int'(src0); default: return int'(rc0); endcase
      1: case (which) 0: return int'(tr1); 1: return int'(run1); 2: return int'(src1); default: return int'(rc1); endcase
      default: case (which) 0: return int'(tr2); 1: return int'(run2); 2: return int'(src2); default: return int'(rc2); endcase
    endcase
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_act[i] = 0; m_armed[i] = 1; m_mode[i] = 0; m_streak[i] = 0;
    m_run_at[i] = 0; m_rc[i] = 0; m_len[i] = 0; m_src[i] = '0;
  endtask

  task automatic model_step(input int i);
    logic [3:0] h;
    bit q, inrun;
    int rcp;
    h = trig & mask & P_WM[i];
    q = |h;
    if (rst) begin
      model_reset(i);
      return;
    end
    inrun = m_act[i] && (ecnt - 1 >= m_run_at[i]);
    rcp   = inrun ? sat(ecnt - 1 - m_run_at[i], i) : m_rc[i];
    if (rearm) begin
      m_rc[i] = rcp; m_act[i] = 0; m_streak[i] = 0; m_armed[i] = 0;
    end else if (inrun && m_mode[i] && m_len[i] != 0 && rcp == m_len[i] - 1) begin
      m_rc[i] = rcp; m_act[i] = 0; m_streak[i] = 0; m_armed[i] = 0;
    end else begin
      if (!m_act[i]) begin
        if (q && (m_armed[i] || m_streak[i] > 0)) begin
          m_streak[i]++;
          if (m_streak[i] == P_D[i]) begin
            m_act[i]    = 1;
            m_run_at[i] = ecnt + P_SD[i];
            m_src[i]    = h;
            m_mode[i]   = mode;
            m_len[i]    = int'(run_len) & P_MAX[i];
            m_streak[i] = 0;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      if (!q) m_armed[i] = 1;
    end
  endtask

  initial begin
    ecnt = 0;
    for (int i = 0; i < 3; i++) model_reset(i);
    forever begin
      @(posedge clk);
      ecnt++;
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d.triggerRst", i), dut_out(i, 0), int'(!exp_run(i)));
        check($sformatf("u%0d.running", i),    dut_out(i, 1), int'(exp_run(i)));
        check($sformatf("u%0d.trig_src", i),   dut_out(i, 2), int'(m_src[i]));
        check($sformatf("u%0d.run_count", i),  dut_out(i, 3), exp_rc(i));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; trig = '0; mask = 4'b0101; mode = 1'b0; run_len = '0; rearm = 1'b0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lit_reset_tr%0d", i),  dut_out(i, 0), 1);
      check($sformatf("lit_reset_run%0d", i), dut_out(i, 1), 0);
      check($sformatf("lit_reset_src%0d", i), dut_out(i, 2), 0);
      check($sformatf("lit_reset_rc%0d", i),  dut_out(i, 3), 0);
    end
    rst = 1'b0;
    tick(1);

    // debounce on the 4-input instance
    trig = 4'b0010; tick(1);
    check("lit_masked_pulse_tr1", int'(tr1), 1);
    trig = 4'b0000; tick(1);
    trig = 4'b0100; tick(2);
    trig = 4'b0000; tick(1);
    check("lit_short_pulse_tr1", int'(tr1), 1);
    trig = 4'b0100; tick(2);
    check("lit_deb_2of3_tr1", int'(tr1), 1);
    tick(1);
    check("lit_deb_accept_run1", int'(run1), 1);
    check("lit_deb_src1", int'(src1), 4'b0100);
    check("lit_deb_rc1", int'(rc1), 0);
    trig = 4'b0000; tick(1);

    // default instance starts immediately; delayed instance waits 4 cycles
    trig = 4'b0001; tick(1);
    check("lit_default_tr0", int'(tr0), 0);
    check("lit_default_rc0", int'(rc0), 0);
    check("lit_delay0_tr2", int'(tr2), 1);
    trig = 4'b0000;
    for (int j = 1; j <= 100; j++) begin
      tick(1);
      check("lit_run_tr0", int'(tr0), 0);
      check("lit_run_rc0", int'(rc0), j);
      if (j < 4) check("lit_delay_tr2", int'(tr2), 1);
      if (j == 4) begin
        check("lit_delay_end_tr2", int'(tr2), 0);
        check("lit_delay_end_rc2", int'(rc2), 0);
      end
    end
    check("lit_sat_rc1", int'(rc1), 15);

    // rearm coincident with a held trigger
    trig = 4'b0001; tick(1);
    rearm = 1'b1; tick(1);
    rearm = 1'b0;
    check("lit_rearm_tr0", int'(tr0), 1);
    check("lit_rearm_tr1", int'(tr1), 1);
    check("lit_rearm_tr2", int'(tr2), 1);
    tick(5);
    check("lit_rearm_hold_tr0", int'(tr0), 1);
    check("lit_rearm_hold_tr1", int'(tr1), 1);
    trig = 4'b0000; tick(1);
    trig = 4'b0001; tick(1);
    check("lit_retrig_run0", int'(run0), 1);
    check("lit_retrig_rc0", int'(rc0), 0);

    // auto-rearm with run_len 5
    rearm = 1'b1; tick(1);
    rearm = 1'b0; mode = 1'b1; run_len = 16'd5; trig = 4'b0000; tick(1);
    trig = 4'b0001;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick(1);
      if (run0) cnt++;
    end
    check("lit_mode1_cycles0", cnt, 5);
    check("lit_mode1_idle_tr0", int'(tr0), 1);
    trig = 4'b0000; tick(1);
    trig = 4'b0001; tick(1);
    check("lit_mode1_restart_run0", int'(run0), 1);
    check("lit_mode1_restart_rc0", int'(rc0), 0);

    // synchronous reset in the middle of a run
    mode = 1'b0; run_len = '0;
    rearm = 1'b1; tick(1);
    rearm = 1'b0; trig = 4'b0000; tick(1);
    trig = 4'b0001; tick(1);
    tick(3);
    check("lit_pre_rst_rc0", int'(rc0), 3);
    rst = 1'b1; tick(1);
    check("lit_rst_tr0", int'(tr0), 1);
    check("lit_rst_run0", int'(run0), 0);
    check("lit_rst_src0", int'(src0), 0);
    check("lit_rst_rc0", int'(rc0), 0);
    check("lit_rst_tr2", int'(tr2), 1);
    rst = 1'b0; tick(1);
    check("lit_rst_release_run0", int'(run0), 1);

    // randomized traffic, checked by the per-cycle model compare
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)  trig = 4'($urandom);
      if ($urandom_range(0, 49) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        mode    = 1'($urandom);
        run_len = 16'($urandom_range(0, 7));
      end
      rearm = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rearm = 1'b0; rst = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
